// File: rtl/gpio_pio_ctrl.sv
// Memory-mapped PIO block: debounced inputs with edge capture/interrupt and a
// set/clear-able output register, exposed over a simple 8-word slave port.
module gpio_pio_ctrl #(
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out,
  output logic                 irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0]  sync1, sync2, stable, stable_nxt, hit;
  logic [IN_WIDTH-1:0]  edge_cap, irq_mask, rise_en, fall_en;
  logic [IN_WIDTH-1:0]  new_edges, clr_mask;
  logic [CNT_W-1:0]     cnt     [IN_WIDTH];
  logic [CNT_W-1:0]     cnt_nxt [IN_WIDTH];
  logic [OUT_WIDTH-1:0] data_out;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // A bit is accepted on the edge its counter would pass DEBOUNCE_CYCLES-1.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) hit[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
    stable_nxt = stable ^ hit;
    new_edges  = (hit & sync2 & rise_en) | (hit & ~sync2 & fall_en);
    clr_mask   = (avs_write && avs_address == 3'd3) ? avs_writedata[IN_WIDTH-1:0] : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0:    rd_mux[IN_WIDTH-1:0]  = stable;
      3'd1:    rd_mux[OUT_WIDTH-1:0] = data_out;
      3'd2:    rd_mux[IN_WIDTH-1:0]  = irq_mask;
      3'd3:    rd_mux[IN_WIDTH-1:0]  = edge_cap;
      3'd6:    rd_mux[IN_WIDTH-1:0]  = rise_en;
      3'd7:    rd_mux[IN_WIDTH-1:0]  = fall_en;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1  <= pio_in;
      sync2  <= sync1;
      stable <= stable_nxt;
      for (int unsigned i = 0; i < IN_WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Edge set is ORed after the clear so a coincident edge survives the W1C.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap     <= '0;
      irq_mask     <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
      data_out     <= OUT_RESET;
      avs_readdata <= '0;
    end else begin
      edge_cap <= (edge_cap & ~clr_mask) | new_edges;
      if (avs_read) avs_readdata <= rd_mux;
      if (avs_write) begin
        case (avs_address)
          3'd1: data_out <= avs_writedata[OUT_WIDTH-1:0];
          3'd2: irq_mask <= avs_writedata[IN_WIDTH-1:0];
          3'd4: data_out <= data_out | avs_writedata[OUT_WIDTH-1:0];
          3'd5: data_out <= data_out & ~avs_writedata[OUT_WIDTH-1:0];
          3'd6: rise_en  <= avs_writedata[IN_WIDTH-1:0];
          3'd7: fall_en  <= avs_writedata[IN_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign pio_out = data_out;
  assign irq     = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_gpio_pio_ctrl.sv
// Directed self-checking bench for gpio_pio_ctrl with a short debounce window.
module tb_gpio_pio_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [3:0]  pio_in = '0;
  logic [7:0]  pio_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  gpio_pio_ctrl #(
    .IN_WIDTH(4),
    .OUT_WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .OUT_RESET(8'h5A)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .pio_in(pio_in),
    .pio_out(pio_out),
    .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Both bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_read = 1'b1; avs_address = a;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_clk);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    bus_read(3'd1, rd);  check("rst_data_out", rd, 32'h5A);
    check("rst_pio_out", {24'b0, pio_out}, 32'h5A);
    bus_read(3'd3, rd);  check("rst_edge_cap", rd, 32'h0);
    bus_read(3'd0, rd);  check("rst_data_in", rd, 32'h0);
    check("rst_irq2", {31'b0, irq}, 32'h0);

    // Rising edge on bit0, exact latency of 2 + 4 cycles
    bus_write(3'd6, 32'h1);
    bus_write(3'd2, 32'hFFFF_FFF1);
    bus_read(3'd2, rd);  check("irq_mask_upper_ignored", rd, 32'h1);
    avs_read = 1'b1; avs_address = 3'd0;
    pio_in = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_clk);
      check($sformatf("rise_irq_c%0d", k), {31'b0, irq}, (k >= 6) ? 32'h1 : 32'h0);
      check($sformatf("rise_din_c%0d", k), avs_readdata, (k >= 7) ? 32'h1 : 32'h0);
    end
    avs_read = 1'b0;
    bus_read(3'd3, rd);  check("rise_edge_cap", rd, 32'h1);

    // 3-cycle glitch on bit1 must be rejected
    bus_write(3'd6, 32'h3);
    pio_in = 4'b0011;
    repeat (3) @(negedge clk_clk);
    pio_in = 4'b0001;
    repeat (10) @(negedge clk_clk);
    bus_read(3'd0, rd);  check("glitch_data_in", rd, 32'h1);
    bus_read(3'd3, rd);  check("glitch_edge_cap", rd, 32'h1);

    // W1C coincident with a new falling edge: edge wins
    bus_write(3'd7, 32'h1);
    bus_read(3'd7, rd);  check("fall_en", rd, 32'h1);
    pio_in = 4'b0000;
    repeat (5) @(negedge clk_clk);
    check("pre_clr_irq", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h1);
    check("clr_vs_edge_irq", {31'b0, irq}, 32'h1);
    bus_read(3'd3, rd);  check("clr_vs_edge_cap", rd, 32'h1);
    bus_read(3'd0, rd);  check("fall_data_in", rd, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_read(3'd3, rd);  check("w0_keeps_cap", rd, 32'h1);
    bus_write(3'd3, 32'h1);
    check("clr_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd3, rd);  check("clr_edge_cap", rd, 32'h0);

    // Output write/set/clear back-to-back, with read-during-write on the first
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 3'd1; avs_writedata = 32'h0F;
    @(negedge clk_clk);
    check("rw_pre_value", avs_readdata, 32'h5A);
    check("out_write", {24'b0, pio_out}, 32'h0F);
    avs_read = 1'b0; avs_address = 3'd4; avs_writedata = 32'hF0;
    @(negedge clk_clk);
    check("out_set", {24'b0, pio_out}, 32'hFF);
    avs_address = 3'd5; avs_writedata = 32'h03;
    @(negedge clk_clk);
    avs_write = 1'b0;
    check("out_clr", {24'b0, pio_out}, 32'hFC);
    check("readdata_hold", avs_readdata, 32'h5A);
    bus_read(3'd4, rd);  check("wo_set_reads_0", rd, 32'h0);
    bus_read(3'd5, rd);  check("wo_clr_reads_0", rd, 32'h0);
    bus_read(3'd1, rd);  check("data_out_rb", rd, 32'hFC);
    bus_write(3'd1, 32'hFFFF_FF33);
    bus_read(3'd1, rd);  check("data_out_upper_ignored", rd, 32'h33);

    // Reset mid-debounce discards the partial count
    pio_in = 4'b0100;
    repeat (4) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    check("midrst_pio_out", {24'b0, pio_out}, 32'h5A);
    check("midrst_readdata", avs_readdata, 32'h0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    avs_read = 1'b1; avs_address = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_clk);
      check($sformatf("rst_relatch_c%0d", k), avs_readdata, (k >= 7) ? 32'h4 : 32'h0);
    end
    avs_read = 1'b0;
    bus_read(3'd3, rd);  check("post_rst_edge_cap", rd, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
